// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register and ALU operand selection.
// Captures the decoded instruction and picks operands from the registered
// values or from newer results still in flight. It also detects hazards that
// forwarding cannot cover, stalling decode and inserting a bubble.
// Optional macro EX_FORWARD_EN: when defined, operands are forwarded from
// EX/MEM and MEM/WB. When undefined, there is no forwarding, and decode is
// stalled until any pending producer has reached MEM/WB.
module ex_operand_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR      = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [REG_ADDR-1:0]      id_rs1,
  input  logic [REG_ADDR-1:0]      id_rs2,
  input  logic [REG_ADDR-1:0]      id_rd,
  input  logic [DATA_WIDTH-1:0]    id_rd1,
  input  logic [DATA_WIDTH-1:0]    id_rd2,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic                     id_alu_src,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     flush,
  input  logic                     exmem_reg_write,
  input  logic [REG_ADDR-1:0]      exmem_rd,
  input  logic [DATA_WIDTH-1:0]    exmem_result,
  input  logic                     memwb_reg_write,
  input  logic [REG_ADDR-1:0]      memwb_rd,
  input  logic [DATA_WIDTH-1:0]    memwb_result,
  output logic                     stall,
  output logic                     ex_valid,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [REG_ADDR-1:0]      ex_rd,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic [15:0]              stall_cycles
);

  localparam logic [REG_ADDR-1:0] X0 = '0;

  logic                     valid_q;
  logic [REG_ADDR-1:0]      rs1_q, rs2_q, rd_q;
  logic [DATA_WIDTH-1:0]    rd1_q, rd2_q, imm_q;
  logic                     alu_src_q, reg_write_q, mem_read_q;
  logic [OPCODE_LENGTH-1:0] alu_op_q;
  logic [15:0]              stall_cnt_q;

  logic                     hz;
  logic [DATA_WIDTH-1:0]    fwd_a, fwd_b;

  assign ex_valid      = valid_q;
  assign ex_reg_write  = reg_write_q & valid_q;
  assign ex_mem_read   = mem_read_q & valid_q;
  assign ex_rd         = rd_q;
  assign Operation     = alu_op_q;
  assign SrcA          = fwd_a;
  assign ex_store_data = fwd_b;
  assign SrcB          = alu_src_q ? imm_q : fwd_b;
  assign stall_cycles  = stall_cnt_q;
  // A redirect kills the waiting instruction, so it never needs to stall.
  assign stall         = hz & ~flush;

  // Hazard detection: load-use always; without forwarding, also any pending ALU/EX-MEM producer
  always_comb begin
    hz = valid_q & mem_read_q & (rd_q != X0) & id_valid &
         ((id_rs1 == rd_q) | (id_rs2 == rd_q));
`ifndef EX_FORWARD_EN
    if (id_valid) begin
      if ((id_rs1 != X0) &&
          ((ex_reg_write && (id_rs1 == rd_q)) || (exmem_reg_write && (id_rs1 == exmem_rd))))
        hz = 1'b1;
      if ((id_rs2 != X0) &&
          ((ex_reg_write && (id_rs2 == rd_q)) || (exmem_reg_write && (id_rs2 == exmem_rd))))
        hz = 1'b1;
    end
`endif
  end

  // Operand selection; the youngest producer (EX/MEM) takes precedence, x0 is never forwarded
  always_comb begin
    fwd_a = rd1_q;
    fwd_b = rd2_q;
`ifdef EX_FORWARD_EN
    if (exmem_reg_write && (exmem_rd != X0) && (exmem_rd == rs1_q))
      fwd_a = exmem_result;
    else if (memwb_reg_write && (memwb_rd != X0) && (memwb_rd == rs1_q))
      fwd_a = memwb_result;
    if (exmem_reg_write && (exmem_rd != X0) && (exmem_rd == rs2_q))
      fwd_b = exmem_result;
    else if (memwb_reg_write && (memwb_rd != X0) && (memwb_rd == rs2_q))
      fwd_b = memwb_result;
`endif
  end

`ifndef EX_FORWARD_EN
  // Without forwarding these inputs and the captured source indices feed nothing.
  wire unused_nofwd = ^{rs1_q, rs2_q, exmem_result, memwb_reg_write, memwb_rd, memwb_result};
`endif

  // ID/EX register: flush and stall only drop valid, the remaining fields are don't-care
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      alu_op_q    <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else if (flush || stall) begin
      valid_q <= 1'b0;
    end else begin
      valid_q     <= id_valid;
      rs1_q       <= id_rs1;
      rs2_q       <= id_rs2;
      rd_q        <= id_rd;
      rd1_q       <= id_rd1;
      rd2_q       <= id_rd2;
      imm_q       <= id_imm;
      alu_src_q   <= id_alu_src;
      alu_op_q    <= id_alu_op;
      reg_write_q <= id_reg_write;
      mem_read_q  <= id_mem_read;
    end
  end

  // Saturating count of cycles spent stalled
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt_q <= '0;
    else if (stall && (stall_cnt_q != 16'hFFFF))
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Testbench for ex_operand_stage: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the stage.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rd1, id_rd2, id_imm;
  logic        id_alu_src;
  logic [3:0]  id_alu_op;
  logic        id_reg_write, id_mem_read, flush;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        stall, ex_valid, ex_reg_write, ex_mem_read;
  logic [31:0] SrcA, SrcB, ex_store_data;
  logic [3:0]  Operation;
  logic [4:0]  ex_rd;
  logic [15:0] stall_cycles;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .stall(stall), .ex_valid(ex_valid), .SrcA(SrcA), .SrcB(SrcB),
    .Operation(Operation), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_store_data(ex_store_data),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Model of the instruction sitting in the EX slot.
  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2, imm;
    logic        alu_src;
    logic [3:0]  op;
    logic        rw, mr;
  } slot_t;

  slot_t       m;
  int unsigned stall_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Does source register r still wait on a result it cannot obtain yet?
  function automatic bit blocked(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (m.valid && m.mr && r == m.rd) return 1'b1;
`ifndef EX_FORWARD_EN
    if (m.valid && m.rw && r == m.rd) return 1'b1;
    if (exmem_reg_write && r == exmem_rd) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic bit exp_stall();
    return id_valid && (blocked(id_rs1) || blocked(id_rs2)) && !flush;
  endfunction

  function automatic logic [31:0] value_of(input logic [4:0] r, input logic [31:0] v);
`ifdef EX_FORWARD_EN
    if (r != 5'd0 && exmem_reg_write && exmem_rd == r) return exmem_result;
    if (r != 5'd0 && memwb_reg_write && memwb_rd == r) return memwb_result;
`endif
    return v;
  endfunction

  // Model advance
  always @(posedge clk) begin
    slot_t nxt;
    nxt = m;
    if (reset) begin
      nxt = '0;
      stall_total <= 0;
    end else begin
      if (exp_stall()) stall_total <= stall_total + 1;
      if (flush || exp_stall()) nxt.valid = 1'b0;
      else nxt = '{id_valid, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm,
                   id_alu_src, id_alu_op, id_reg_write, id_mem_read};
    end
    m <= nxt;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", {31'd0, stall}, {31'd0, exp_stall()});
      check("ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
      check("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m.valid & m.rw});
      check("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m.valid & m.mr});
      check("stall_cycles", {16'd0, stall_cycles},
            (stall_total > 65535) ? 32'hFFFF : stall_total);
      if (m.valid) begin
        check("SrcA", SrcA, value_of(m.rs1, m.rd1));
        check("ex_store_data", ex_store_data, value_of(m.rs2, m.rd2));
        check("SrcB", SrcB, m.alu_src ? m.imm : value_of(m.rs2, m.rd2));
        check("Operation", {28'd0, Operation}, {28'd0, m.op});
        check("ex_rd", {27'd0, ex_rd}, {27'd0, m.rd});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rd1 = 0; id_rd2 = 0; id_imm = 0; id_alu_src = 0; id_alu_op = 0;
    id_reg_write = 0; id_mem_read = 0; flush = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic id_load(input logic [4:0] rd);
    idle();
    id_valid = 1; id_rd = rd; id_mem_read = 1; id_reg_write = 1;
  endtask

  initial begin
    reset = 1;
    idle();
    tick();
    chk_en = 1'b1;
    tick();
    reset = 0;

    // Reset state
    check("rst ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst SrcA", SrcA, 32'd0);
    check("rst SrcB", SrcB, 32'd0);
    check("rst store", ex_store_data, 32'd0);
    check("rst Operation", {28'd0, Operation}, 32'd0);
    check("rst ex_rd", {27'd0, ex_rd}, 32'd0);
    check("rst stall", {31'd0, stall}, 32'd0);
    check("rst cycles", {16'd0, stall_cycles}, 32'd0);

    // Basic capture, one cycle latency
    id_valid = 1; id_rs1 = 1; id_rd1 = 5; id_rs2 = 2; id_rd2 = 9;
    id_imm = 7; id_alu_src = 1; id_alu_op = 4'b0010; id_rd = 6; id_reg_write = 1;
    tick();
    check("cap SrcA", SrcA, 32'd5);
    check("cap SrcB", SrcB, 32'd7);
    check("cap Operation", {28'd0, Operation}, 32'd2);
    check("cap ex_valid", {31'd0, ex_valid}, 32'd1);
    check("cap store", ex_store_data, 32'd9);
    idle();
    tick();

`ifdef EX_FORWARD_EN
    // Forwarding priority
    id_valid = 1; id_rs1 = 3; id_rd1 = 1;
    tick();
    idle();
    exmem_reg_write = 1; exmem_rd = 3; exmem_result = 100;
    memwb_reg_write = 1; memwb_rd = 3; memwb_result = 50;
    #1 check("fwd exmem", SrcA, 32'd100);
    exmem_reg_write = 0;
    #1 check("fwd memwb", SrcA, 32'd50);
    memwb_rd = 0;
    #1 check("fwd x0", SrcA, 32'd1);
    idle();
    tick();
    reset = 1; tick(); reset = 0;
`else
    // ALU producer without forwarding: two stall cycles, then register-file value
    idle(); id_valid = 1; id_rd = 5; id_reg_write = 1;
    tick();
    idle(); id_valid = 1; id_rs1 = 5; id_rd1 = 11; id_rd = 8;
    #1 check("alu stall1", {31'd0, stall}, 32'd1);
    tick();
    exmem_reg_write = 1; exmem_rd = 5; exmem_result = 42;
    #1 check("alu stall2", {31'd0, stall}, 32'd1);
    check("alu bubble", {31'd0, ex_valid}, 32'd0);
    tick();
    exmem_reg_write = 0; memwb_reg_write = 1; memwb_rd = 5; memwb_result = 42; id_rd1 = 42;
    #1 check("alu nostall", {31'd0, stall}, 32'd0);
    tick();
    check("alu SrcA", SrcA, 32'd42);
    check("alu ex_valid", {31'd0, ex_valid}, 32'd1);
    check("alu cycles", {16'd0, stall_cycles}, 32'd2);
    reset = 1; idle(); tick(); reset = 0;
`endif

    // Load-use: one bubble, then the value arrives via MEM/WB (or the register file)
    id_load(4);
    tick();
    idle(); id_valid = 1; id_rs2 = 4; id_rd = 9; id_rd2 = 77;
    #1 check("lu stall", {31'd0, stall}, 32'd1);
    tick();
    check("lu bubble", {31'd0, ex_valid}, 32'd0);
    check("lu cycles", {16'd0, stall_cycles}, 32'd1);
    memwb_reg_write = 1; memwb_rd = 4; memwb_result = 77;
    #1 check("lu release", {31'd0, stall}, 32'd0);
    tick();
    check("lu ex_valid", {31'd0, ex_valid}, 32'd1);
    check("lu SrcB", SrcB, 32'd77);

    // Load-use with flush: flush wins, not counted
    id_load(4);
    tick();
    idle(); id_valid = 1; id_rs2 = 4; flush = 1;
    #1 check("fl stall", {31'd0, stall}, 32'd0);
    tick();
    check("fl ex_valid", {31'd0, ex_valid}, 32'd0);
    check("fl cycles", {16'd0, stall_cycles}, 32'd1);
    idle();
    tick();

`ifndef EX_FORWARD_EN
    // Held hazard saturates the counter
    id_valid = 1; id_rs1 = 7; exmem_reg_write = 1; exmem_rd = 7;
    repeat (65540) tick();
    check("sat cycles", {16'd0, stall_cycles}, 32'hFFFF);
    check("sat stall", {31'd0, stall}, 32'd1);
    idle();
    tick();
`endif

    // Reset in the middle of a load-use stall
    id_load(4);
    id_rd1 = 3; id_imm = 2; id_alu_op = 4'hA;
    tick();
    idle(); id_valid = 1; id_rs2 = 4;
    #1 check("mr stall", {31'd0, stall}, 32'd1);
    reset = 1;
    tick();
    reset = 0;
    check("mr stall after", {31'd0, stall}, 32'd0);
    check("mr ex_valid", {31'd0, ex_valid}, 32'd0);
    check("mr cycles", {16'd0, stall_cycles}, 32'd0);
    check("mr SrcA", SrcA, 32'd0);
    check("mr Operation", {28'd0, Operation}, 32'd0);
    check("mr ex_rd", {27'd0, ex_rd}, 32'd0);

    // Randomized traffic with small register indices to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      id_valid = $urandom_range(0, 3) != 0;
      id_rs1 = 5'($urandom_range(0, 7));
      id_rs2 = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7));
      id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
      id_alu_src = 1'($urandom_range(0, 1));
      id_alu_op = 4'($urandom_range(0, 15));
      id_reg_write = 1'($urandom_range(0, 1));
      id_mem_read = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 7) == 0);
      exmem_reg_write = 1'($urandom_range(0, 1));
      exmem_rd = 5'($urandom_range(0, 7));
      exmem_result = $urandom;
      memwb_reg_write = 1'($urandom_range(0, 1));
      memwb_rd = 5'($urandom_range(0, 7));
      memwb_result = $urandom;
      tick();
    end
    reset = 0;
    idle();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register and operand-selection stage sitting directly upstream of the execute-stage ALU. It captures decoded instruction fields, resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages, and detects load-use hazards, stalling the front end and inserting bubbles as required. It handles branch-redirect flushes. It drives the ALU's `SrcA`, `SrcB` and `Operation` inputs directly.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand/result width
- `OPCODE_LENGTH`, 4, ALU operation code width
- `REG_ADDR`, 5, register index width

Ports:
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `id_valid`  in  1  decode presents a live instruction
- `id_rs1`, `id_rs2`, `id_rd`  in  REG_ADDR  source/destination indices
- `id_rd1`, `id_rd2`  in  DATA_WIDTH  register-file read data
- `id_imm`  in  DATA_WIDTH  sign-extended immediate
- `id_alu_src`  in  1  1: SrcB = immediate
- `id_alu_op`  in  OPCODE_LENGTH  ALU operation
- `id_reg_write`, `id_mem_read`  in  1  writes rd / is a load
- `flush`  in  1  branch redirect, kill ID instruction
- `exmem_reg_write`  in  1; `exmem_rd`  in  REG_ADDR; `exmem_result`  in  DATA_WIDTH  EX/MEM writeback info
- `memwb_reg_write`  in  1; `memwb_rd`  in  REG_ADDR; `memwb_result`  in  DATA_WIDTH  MEM/WB writeback info
- `stall`  out  1  hold PC and IF/ID (combinational)
- `ex_valid`  out  1  EX slot holds a live instruction
- `SrcA`, `SrcB`  out  DATA_WIDTH  ALU operands
- `Operation`  out  OPCODE_LENGTH  ALU operation
- `ex_rd`  out  REG_ADDR; `ex_reg_write`, `ex_mem_read`  out  1  forwarded downstream
- `ex_store_data`  out  DATA_WIDTH  forwarded rs2 value, before the immediate mux
- `stall_cycles`  out  16  saturating count of stall cycles

## Operation
- Register contents: valid, rs1, rs2, rd, rd1, rd2, imm, alu_src, alu_op, reg_write, mem_read.
- Each edge, one of the following applies, highest priority first:
  - `reset`: valid = 0, all fields = 0, `stall_cycles` = 0.
  - `flush`: valid = 0.
  - `stall`: valid = 0 (bubble). ID fields are not consumed; decode holds them.
  - otherwise: load all fields from `id_*`, valid = `id_valid`.
- Gating: `ex_reg_write` = reg_write & valid. `ex_mem_read` = mem_read & valid.
- Load-use hazard `hz` = valid & mem_read & (rd != 0) & `id_valid` & (`id_rs1` == rd | `id_rs2` == rd).
- `stall` = `hz` & ~`flush`.
- Forwarding for each source s ∈ {rs1, rs2}, registered value v:
  - If `exmem_reg_write` & `exmem_rd` != 0 & `exmem_rd` == s: use `exmem_result`.
  - Else if `memwb_reg_write` & `memwb_rd` != 0 & `memwb_rd` == s: use `memwb_result`.
  - Else: use v.
- Outputs:
  - `SrcA` = fwd(rs1).
  - `ex_store_data` = fwd(rs2).
  - `SrcB` = alu_src ? imm : fwd(rs2).
  - `Operation` = alu_op.
- Source x0 is never forwarded. It always yields the registered value, which the register file returns as 0.
- `stall_cycles` increments on each edge where `stall` = 1 and saturates at 16'hFFFF.

## Timing
- Reset values:
  - `ex_valid`, `ex_reg_write`, `ex_mem_read`, `stall` = 0.
  - `SrcA`, `SrcB`, `ex_store_data` = 0 when no forward matches.
  - `Operation` = 4'b0000, `ex_rd` = 0, `stall_cycles` = 0.
- Latency: an ID instruction appears at the EX outputs 1 cycle after capture.
- Forwarding muxes and `stall` are combinational within the cycle. No registered output depends on them.
- Load-use: exactly 1 bubble cycle. The dependent instruction then forwards from MEM/WB.
- `flush` together with `hz`: `flush` wins, no stall, and the stall is not counted.
- `reset` mid-stall: the bubble is dropped, `stall` is 0 after the edge, and the counter clears.
- Forwarding from EX/MEM and MEM/WB to the same register: EX/MEM (youngest) wins.

## Configuration
- `EX_FORWARD_EN` defined: forwarding as above.
- Undefined: all forwarding paths removed, so `SrcA`/`SrcB`/`ex_store_data` come only from registered values.
  - `hz` is extended to stall while an `id_rs1`/`id_rs2` (nonzero) matches `ex_rd` with `ex_reg_write`, or matches `exmem_rd` with `exmem_reg_write`.
  - MEM/WB relies on the register file's write-before-read.
  - Bubble insertion, flush priority and the counter are unchanged.

## Test plan
- Reset, then `id_valid` = 1, rs1 = 1 (`id_rd1` = 5), `id_imm` = 7, `id_alu_src` = 1, op = 4'b0010 -> next cycle `SrcA` = 5, `SrcB` = 7, `Operation` = 4'b0010, `ex_valid` = 1.
- EX/MEM writes x3 = 100 and MEM/WB writes x3 = 50; EX instruction reads rs1 = 3 -> `SrcA` = 100. With the EX/MEM write removed -> 50. With rd = 0 -> registered value.
- Load to x4 in EX; ID reads rs2 = 4 -> `stall` = 1 for 1 cycle, `ex_valid` = 0 next cycle, `stall_cycles` = 1. Dependent instruction enters EX one cycle later and forwards from MEM/WB.
- Same load-use hazard with `flush` = 1 -> `stall` = 0, `ex_valid` = 0 next cycle, `stall_cycles` unchanged.
- Hold the hazard for 70000 cycles -> `stall_cycles` = 16'hFFFF. Assert `reset` mid-stall -> all outputs return to reset values on the next edge.
- Without `EX_FORWARD_EN`: ALU write to x5 in EX, ID reads x5 -> 2 stall cycles, then `SrcA` = register-file value.
